multicycle_sequencer: RTL

Parametrised control sequencer for the multi-cycle core that succeeds the single-cycle top. It owns the PC and instruction register and steps each instruction through fetch, decode, execute, memory and writeback phases. Instruction and data memories are reached through valid/ready request plus response-valid handshakes, so memories of any latency can be attached. The existing decoder, ALU, register file and load/store interface stay combinational around it; this block supplies their enables.

---
 rtl/core_seq_pkg.sv | 23 ++
 rtl/multicycle_sequencer.sv | 102 ++++++++++
 2 files changed

// File: rtl/core_seq_pkg.sv
// Shared types and constants for the multi-cycle core control sequencer.
package core_seq_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    IWAIT  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    MWAIT  = 3'd5,
    WB     = 3'd6,
    HALT   = 3'd7
  } seq_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          PC_STEP   = 4;

  // Instruction addresses must be word aligned.
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/multicycle_sequencer.sv
// Control sequencer for the multi-cycle core: owns PC/IR and steps each
// instruction through fetch, decode, execute, memory and writeback.
module multicycle_sequencer
  import core_seq_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             imem_req_valid,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  output logic [31:0]      instr,
  output logic [XLEN-1:0]  pc,
  input  logic             dec_reg_write,
  input  logic             dec_is_load,
  input  logic             dec_is_store,
  input  logic             dec_redirect,
  input  logic [XLEN-1:0]  dec_target,
  output logic             dmem_req_valid,
  output logic             dmem_req_we,
  input  logic             dmem_req_ready,
  input  logic             dmem_rsp_valid,
  output logic             rf_we,
  output logic             wb_sel_mem,
  output logic             retire,
  output logic [CNT_W-1:0] retire_count,
  output logic             halted
);

  seq_state_t       state, state_next;
  logic [XLEN-1:0]  pc_reg;
  logic [XLEN-1:0]  next_pc;
  logic [31:0]      instr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             fetch_hold;

  // en only gates the start of a fetch; once raised the request is held
  // by fetch_hold until it is accepted.
  assign imem_req_valid = (state == FETCH) && !rst && (en || fetch_hold);
  assign imem_req_addr  = pc_reg;
  assign dmem_req_valid = (state == MEM);
  assign dmem_req_we    = dec_is_store;
  assign rf_we          = (state == WB) && dec_reg_write;
  assign wb_sel_mem     = (state == WB) && dec_is_load && !dec_is_store;
  assign retire         = (state == WB);
  assign halted         = (state == HALT);
  assign instr          = instr_reg;
  assign pc             = pc_reg;
  assign retire_count   = count_reg;

  always_comb begin
    state_next = state;
    case (state)
      FETCH:  if (imem_req_valid && imem_req_ready) state_next = IWAIT;
              else                                  state_next = FETCH;
      IWAIT:  if (imem_rsp_valid) state_next = DECODE;
              else                state_next = IWAIT;
      DECODE: state_next = EXEC;
      EXEC: begin
        if (dec_redirect && is_misaligned(dec_target[1:0])) state_next = HALT;
        else if (dec_is_load || dec_is_store)              state_next = MEM;
        else                                               state_next = WB;
      end
      MEM:    if (dmem_req_ready) state_next = MWAIT;
              else                state_next = MEM;
      MWAIT:  if (dmem_rsp_valid) state_next = WB;
              else                state_next = MWAIT;
      WB:     state_next = FETCH;
      HALT:   state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH;
      pc_reg     <= RESET_PC;
      next_pc    <= RESET_PC;
      instr_reg  <= NOP_INSTR;
      count_reg  <= '0;
      fetch_hold <= 1'b0;
    end else begin
      state      <= state_next;
      fetch_hold <= imem_req_valid && !imem_req_ready;
      if (state == IWAIT && imem_rsp_valid) instr_reg <= imem_rsp_data;
      // pc + 4 wraps naturally at the XLEN boundary.
      if (state == EXEC)
        next_pc <= dec_redirect ? dec_target : pc_reg + XLEN'(PC_STEP);
      if (state == WB) begin
        pc_reg    <= next_pc;
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

endmodule
